// File: rtl/kbd_pkg.sv
// Shared types and helpers for the PS/2 keyboard receiver and its FIFO.
package kbd_pkg;

  localparam int unsigned FrameBits = 11;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCheck
  } rx_state_e;

  // Data byte plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_kbd_fifo_if.sv
// Bus-side read port of the keyboard FIFO: read strobe in, status and head byte out.
interface ps2_kbd_fifo_if;
  logic       io_rdn;
  logic       ready;
  logic [7:0] key_data;
  logic       overflow;

  modport master (output io_rdn, input ready, key_data, overflow);
  modport slave  (input io_rdn, output ready, key_data, overflow);
endinterface

// File: rtl/kbd_fifo.sv
// Synchronous FIFO; a push while full is accepted only when a pop frees a slot that cycle.
module kbd_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: oversampled pins, 11-bit frame FSM with timeout, scan-code FIFO
// popped once per active-low bus read strobe.
module ps2_kbd_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_kbd_fifo_if.slave  bus
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);
  localparam logic [3:0] LastBit = 4'(FrameBits - 2);

  logic       clk_s1_q, clk_s2_q, clk_s3_q;
  logic       dat_s1_q, dat_s2_q;
  logic       fall;

  rx_state_e  state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [9:0] shift_q, shift_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic       rdn_q;
  logic       pop, push_req, full, empty, frame_ok;
  logic       overflow_q;
  logic [7:0] head;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      rdn_q    <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      rdn_q    <= bus.io_rdn;
    end
  end

  assign fall = clk_s3_q & ~clk_s2_q;

  // shift_q after a full frame: [7:0] data, [8] parity, [9] stop.
  assign frame_ok = shift_q[9] & odd_parity_ok(shift_q[8:0]);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = '0;
    push_req  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall && !dat_s2_q) begin
          state_d   = StShift;
          bit_cnt_d = '0;
        end
      end
      StShift: begin
        if (fall) begin
          shift_d   = {dat_s2_q, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastBit) state_d = StCheck;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TmoMax) state_d = StIdle;
        end
      end
      StCheck: begin
        push_req = frame_ok;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
    end
  end

  // One pop per strobe: only the first low cycle after a high one counts.
  assign pop = rdn_q & ~bus.io_rdn & ~empty;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      overflow_q <= 1'b0;
    end else if (push_req && full && !pop) begin
      overflow_q <= 1'b1;
    end else if (pop) begin
      overflow_q <= 1'b0;
    end
  end

  kbd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (clrn),
    .push_i  (push_req),
    .wdata_i (shift_q[7:0]),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.ready    = ~empty;
  assign bus.key_data = head;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Scoreboard bench: bytes expected in the FIFO are queued as frames are sent, checked on reads.
module tb_ps2_kbd_fifo;

  localparam int unsigned Depth = 8;
  localparam int unsigned Tmo   = 1000;

  logic clk = 1'b0;
  logic clrn;
  logic ps2_clk;
  logic ps2_data;

  ps2_kbd_fifo_if bus ();

  ps2_kbd_fifo #(
    .FIFO_DEPTH     (Depth),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  exp_q[$];
  logic        exp_ovf  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: checks head/status against the model, then strobes io_rdn.
  task automatic rd(input string tag, input int n_low);
    logic [7:0] exp_head;
    exp_head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    check_eq({tag, "_ready"}, 32'(bus.ready), 32'(exp_q.size() != 0));
    check_eq({tag, "_key"}, 32'(bus.key_data), 32'(exp_head));
    check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
    bus.io_rdn = 1'b0;
    cycles(n_low);
    bus.io_rdn = 1'b1;
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      exp_ovf = 1'b0;
    end
    cycles(2);
  endtask

  task automatic send(input logic [7:0] d, input bit bad_par, input bit stop_v,
                      input int nbits, input bit rd_at_stop);
    logic [10:0] b;
    b = {stop_v, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = b[i];
      cycles(4);
      ps2_clk = 1'b0;
      if (i == 10 && rd_at_stop) begin
        // Strobe lands in the same cycle the receiver pushes this frame.
        cycles(3);
        rd("same_cycle", 1);
        cycles(3);
      end else begin
        cycles(8);
      end
      ps2_clk = 1'b1;
      cycles(4);
    end
    ps2_data = 1'b1;
    cycles(6);
    if (nbits == 11 && !bad_par && stop_v) begin
      if (exp_q.size() < Depth) exp_q.push_back(d);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic check_empty(input string tag);
    check_eq({tag, "_ready"}, 32'(bus.ready), 32'(exp_q.size() != 0));
    check_eq({tag, "_key"}, 32'(bus.key_data), 32'h0);
  endtask

  initial begin
    logic [7:0] fill [9];
    fill = '{8'h01, 8'h22, 8'h43, 8'h64, 8'h85, 8'hA6, 8'hC7, 8'hE8, 8'h5A};
    clrn        = 1'b0;
    ps2_clk     = 1'b1;
    ps2_data    = 1'b1;
    bus.io_rdn  = 1'b1;
    cycles(3);
    check_eq("rst_ready", 32'(bus.ready), 32'h0);
    check_eq("rst_key", 32'(bus.key_data), 32'h0);
    check_eq("rst_ovf", 32'(bus.overflow), 32'h0);
    clrn = 1'b1;
    cycles(2);

    // Single frame, long strobe: exactly one pop.
    send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    rd("one", 3);
    check_empty("one_after");

    // Back-to-back frames, then a strobe while empty.
    send(8'hF0, 1'b0, 1'b1, 11, 1'b0);
    send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    send(8'h12, 1'b0, 1'b1, 11, 1'b0);
    for (int i = 0; i < 3; i++) rd("seq", 1);
    rd("empty_rd", 2);
    check_empty("empty_after");

    // Overflow: nine frames into an eight-deep FIFO.
    for (int i = 0; i < 9; i++) send(fill[i], 1'b0, 1'b1, 11, 1'b0);
    check_eq("ovf_set", 32'(bus.overflow), 32'(exp_ovf));
    for (int i = 0; i < 8; i++) rd("ovf_drain", 1);
    check_empty("ovf_after");

    // Bad parity and bad stop bit are dropped silently.
    send(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    send(8'h1C, 1'b0, 1'b0, 11, 1'b0);
    check_empty("bad_frames");
    check_eq("bad_ovf", 32'(bus.overflow), 32'h0);

    // Stalled partial frame is discarded by the timeout.
    send(8'h55, 1'b0, 1'b1, 5, 1'b0);
    cycles(Tmo + 100);
    send(8'h2A, 1'b0, 1'b1, 11, 1'b0);
    rd("tmo", 1);
    check_empty("tmo_after");

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 8; i++) send(fill[i], 1'b0, 1'b1, 11, 1'b0);
    send(8'h77, 1'b0, 1'b1, 11, 1'b1);
    check_eq("same_ovf", 32'(bus.overflow), 32'h0);
    for (int i = 0; i < 8; i++) rd("same_drain", 1);
    check_empty("same_after");

    // Reset mid-frame with data queued.
    send(8'h33, 1'b0, 1'b1, 11, 1'b0);
    send(8'h44, 1'b0, 1'b1, 5, 1'b0);
    check_eq("pre_rst_ready", 32'(bus.ready), 32'h1);
    clrn = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    check_eq("midrst_ready", 32'(bus.ready), 32'h0);
    check_eq("midrst_key", 32'(bus.key_data), 32'h0);
    check_eq("midrst_ovf", 32'(bus.overflow), 32'h0);
    cycles(2);
    clrn = 1'b1;
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
